// File: rtl/tta_pkg.sv
// Shared transport-bus encodings and types for the TTA function-unit ports.
// Also used by the bus decoder so destination selects stay consistent.
package tta_pkg;

  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    DST_OPA  = 2'd0,
    DST_ADD  = 2'd1,
    DST_SUB  = 2'd2,
    DST_RSVD = 2'd3
  } dst_sel_e;

  // In-flight operation marker carried alongside the unit pipeline.
  typedef struct packed {
    logic valid;
    logic sub;
  } tag_t;

endpackage

// File: rtl/u24_result_fifo.sv
// Small circular result buffer; push and pop may coincide at any fill level.
// The head word is presented combinationally.
module u24_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose so the head reads 0 after reset;
      // this is cheap at this depth but would not be done for a large RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/u24_fu_port.sv
// Transport-bus front end for the registered 24-bit add/sub units: operand capture,
// trigger issue, in-flight tracking and result buffering for source moves.
module u24_fu_port
  import tta_pkg::*;
#(
  parameter int FU_LATENCY   = 1,
  parameter int RESULT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dst_valid,
  input  logic [1:0]        dst_sel,
  input  logic [DATA_W-1:0] dst_data,
  output logic              dst_ready,
  output logic [DATA_W-1:0] fu_opa,
  output logic [DATA_W-1:0] fu_opb,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] sub_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_read,
  output logic              rd_err
);

  localparam int STAGES = FU_LATENCY + 1;
  localparam int CNT_W  = $clog2(RESULT_DEPTH) + 1;
  localparam int OCC_W  = $clog2(RESULT_DEPTH + STAGES + 1) + 1;

  dst_sel_e          sel;
  logic [DATA_W-1:0] opa_reg;
  tag_t              tag_sr [STAGES];
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic              is_trig;
  logic              trig_ready;
  logic              trig_fire;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] push_data;

  assign sel     = dst_sel_e'(dst_sel);
  assign is_trig = (sel == DST_ADD) || (sel == DST_SUB);

  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + OCC_W'(tag_sr[i].valid);
  end

  // Reserve a FIFO slot per in-flight op; a same-cycle pop frees one slot.
  assign pop        = res_read & ~fifo_empty;
  assign occ        = OCC_W'(fifo_count) + inflight;
  assign trig_ready = (occ - OCC_W'(pop)) < OCC_W'(RESULT_DEPTH);
  assign dst_ready  = is_trig ? trig_ready : 1'b1;
  assign trig_fire  = dst_valid & is_trig & trig_ready;

  assign push      = tag_sr[FU_LATENCY].valid;
  assign push_data = tag_sr[FU_LATENCY].sub ? sub_result : add_result;
  assign res_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_reg <= '0;
      fu_opa  <= '0;
      fu_opb  <= '0;
      rd_err  <= 1'b0;
      for (int i = 0; i < STAGES; i++) tag_sr[i] <= '0;
    end else begin
      if (dst_valid && sel == DST_OPA) opa_reg <= dst_data;
      if (trig_fire) begin
        fu_opa <= opa_reg;
        fu_opb <= dst_data;
      end
      tag_sr[0] <= '{valid: trig_fire, sub: (sel == DST_SUB)};
      for (int i = 1; i < STAGES; i++) tag_sr[i] <= tag_sr[i-1];
      rd_err <= res_read & fifo_empty;
    end
  end

  u24_result_fifo #(
    .DEPTH(RESULT_DEPTH),
    .W    (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (res_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Admission control must make a push into a full buffer without a pop impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_u24_fu_port.sv
// Self-checking bench for u24_fu_port with behavioural add/sub units attached.
// Directed vector table, hand sequences for stall/reset corners, then random moves vs a queue model.
module tb_u24_fu_port;
  import tta_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        dst_valid;
  logic [1:0]  dst_sel;
  logic [23:0] dst_data;
  logic        dst_ready;
  logic [23:0] fu_opa;
  logic [23:0] fu_opb;
  logic [23:0] add_result;
  logic [23:0] sub_result;
  logic        res_valid;
  logic [23:0] res_data;
  logic        res_read;
  logic        rd_err;

  int checks = 0;
  int errors = 0;

  u24_fu_port #(
    .FU_LATENCY  (1),
    .RESULT_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dst_valid (dst_valid),
    .dst_sel   (dst_sel),
    .dst_data  (dst_data),
    .dst_ready (dst_ready),
    .fu_opa    (fu_opa),
    .fu_opb    (fu_opb),
    .add_result(add_result),
    .sub_result(sub_result),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_read  (res_read),
    .rd_err    (rd_err)
  );

  // Registered single-stage add/sub units (latency 1).
  always @(posedge clk) begin
    add_result <= fu_opa + fu_opb;
    sub_result <= fu_opa - fu_opb;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of expected results, each with the edge from which it is visible.
  typedef struct {
    logic [23:0] data;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  logic [23:0] m_opa;
  logic [23:0] m_fa;
  logic [23:0] m_fb;
  logic        m_rderr;
  int          cyc;

  logic        obs_ready;
  logic        obs_rv;
  logic [23:0] obs_data;
  logic        obs_rderr;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [23:0] d;
    logic        rd;
    logic        e_ready;
    logic        e_rv;
    logic [23:0] e_data;
    logic        e_rderr;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_opa   = '0;
    m_fa    = '0;
    m_fb    = '0;
    m_rderr = 1'b0;
  endtask

  // One bus cycle: drive at posedge+1, sample mid-cycle, compare with model, advance model after edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [23:0] d, input logic rd);
    logic        exp_valid;
    logic        exp_ready;
    logic        trig;
    logic [23:0] r;
    dst_valid = v;
    dst_sel   = sel;
    dst_data  = d;
    res_read  = rd;
    #3;
    obs_ready = dst_ready;
    obs_rv    = res_valid;
    obs_data  = res_data;
    obs_rderr = rd_err;
    exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
    trig      = (sel == DST_ADD) || (sel == DST_SUB);
    exp_ready = trig ? ((q.size() - ((rd && exp_valid) ? 1 : 0)) < 2) : 1'b1;
    check("model_dst_ready", dst_ready, exp_ready);
    check("model_res_valid", res_valid, exp_valid);
    check("model_rd_err", rd_err, m_rderr);
    check("model_fu_opa", fu_opa, m_fa);
    check("model_fu_opb", fu_opb, m_fb);
    if (exp_valid) check("model_res_data", res_data, q[0].data);
    @(posedge clk);
    #1;
    cyc++;
    if (rd && exp_valid) void'(q.pop_front());
    if (v && trig && exp_ready) begin
      r = (sel == DST_SUB) ? (m_opa - d) : (m_opa + d);
      q.push_back('{data: r, rdy: cyc + 2});
      m_fa = m_opa;
      m_fb = d;
    end
    if (v && sel == DST_OPA) m_opa = d;
    m_rderr = rd && !exp_valid;
  endtask

  initial begin
    logic [23:0] got[$];

    rst_n     = 1'b0;
    dst_valid = 1'b0;
    dst_sel   = 2'd0;
    dst_data  = '0;
    res_read  = 1'b0;
    model_reset();
    cyc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_res_data", res_data, 24'h0);
    check("reset_rd_err", rd_err, 1'b0);
    check("reset_fu_opa", fu_opa, 24'h0);
    check("reset_fu_opb", fu_opb, 24'h0);
    check("reset_dst_ready", dst_ready, 1'b1);
    rst_n = 1'b1;

    // Directed table: add, sub wrap, add wrap, empty read, reserved select.
    tbl[0]  = '{1'b1, 2'd0, 24'h000005, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[1]  = '{1'b1, 2'd1, 24'h000003, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[2]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[3]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[4]  = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h000008, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[6]  = '{1'b1, 2'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[7]  = '{1'b1, 2'd2, 24'h000001, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[8]  = '{1'b1, 2'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[9]  = '{1'b1, 2'd1, 24'h000001, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[10] = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[12] = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[14] = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[15] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b1};
    tbl[16] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[17] = '{1'b1, 2'd3, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[18] = '{1'b1, 2'd2, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[19] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[20] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};
    tbl[21] = '{1'b0, 2'd0, 24'h0,      1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b0};
    tbl[22] = '{1'b0, 2'd0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h0,      1'b0};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rd);
      check($sformatf("vec%0d_dst_ready", i), obs_ready, tbl[i].e_ready);
      check($sformatf("vec%0d_res_valid", i), obs_rv, tbl[i].e_rv);
      check($sformatf("vec%0d_rd_err", i), obs_rderr, tbl[i].e_rderr);
      if (tbl[i].e_rv) check($sformatf("vec%0d_res_data", i), obs_data, tbl[i].e_data);
    end

    // Back-to-back triggers: third stalls until a read frees a slot in the same cycle.
    step(1'b1, 2'd0, 24'h000100, 1'b0);
    step(1'b1, 2'd1, 24'h000001, 1'b0);
    step(1'b1, 2'd1, 24'h000002, 1'b0);
    step(1'b1, 2'd1, 24'h000003, 1'b0);
    check("t3_third_stalled", obs_ready, 1'b0);
    step(1'b1, 2'd1, 24'h000003, 1'b1);
    check("t3_third_accepted", obs_ready, 1'b1);
    check("t3_first_result", obs_data, 24'h000101);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'd0, 24'h0, 1'b1);
      if (obs_rv) got.push_back(obs_data);
    end
    check("t3_drain_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t3_second_result", got[0], 24'h000102);
      check("t3_third_result", got[1], 24'h000103);
    end

    // Streaming: simultaneous push and pop while the buffer stays at its limit.
    step(1'b1, 2'd0, 24'h000010, 1'b0);
    step(1'b1, 2'd1, 24'h000001, 1'b0);
    step(1'b1, 2'd2, 24'h000002, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'(1 + (i % 2)), 24'(i + 3), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 24'h0, 1'b1);
    check("t4_model_drained", q.size(), 0);

    // Reset with an op in flight: nothing may surface after release.
    step(1'b1, 2'd0, 24'h000007, 1'b0);
    step(1'b1, 2'd1, 24'h000001, 1'b0);
    step(1'b0, 2'd0, 24'h0, 1'b0);
    rst_n     = 1'b0;
    dst_valid = 1'b0;
    res_read  = 1'b0;
    #3;
    check("t6_reset_res_valid", res_valid, 1'b0);
    check("t6_reset_fu_opa", fu_opa, 24'h0);
    check("t6_reset_fu_opb", fu_opb, 24'h0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 24'h0, 1'b0);
      check("t6_no_stale_result", obs_rv, 1'b0);
    end

    // Randomised moves against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
